// File: rtl/uart_frame_tx.sv
// uart_frame_tx: serialises a multi-byte frame onto a UART line.
// Bytes go out most-significant byte first, bits LSB first, each byte
// framed by one start bit and STOP_BITS stop bits, with no gap between
// bytes of the same frame. One serial bit per rising edge of clk_N.
//
// Handshake: a frame is accepted on a rising edge where tx_valid_i and
// tx_ready_o are both high; tx_ready_o is high only while idle, so
// frame_i and tx_valid_i are ignored for the whole transmission.
// done_o pulses for one cycle on the edge the final stop bit ends,
// the same edge tx_ready_o returns high.
module uart_frame_tx #(
    parameter int MAX_BITS   = 8,
    parameter int PARAMETERS = 6,
    parameter int STOP_BITS  = 1
) (
    input  logic                           clk_N,
    input  logic                           rst_i,
    input  logic [MAX_BITS*PARAMETERS-1:0] frame_i,
    input  logic                           tx_valid_i,
    output logic                           tx_ready_o,
    output logic                           UART_TX,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int FW = MAX_BITS * PARAMETERS;
    localparam int BW = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam int YW = (PARAMETERS > 1) ? $clog2(PARAMETERS) : 1;
    localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

    localparam logic [BW-1:0] BIT_LAST  = BW'(MAX_BITS - 1);
    localparam logic [YW-1:0] BYTE_LAST = YW'(PARAMETERS - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

    // state_q names the symbol currently on the line (IDLE = idle high)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   shift_q, shift_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [YW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [SW-1:0]   stop_cnt_q, stop_cnt_d;
    logic            tx_q, tx_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [MAX_BITS-1:0] cur_byte;

    assign cur_byte   = shift_q[FW-1 -: MAX_BITS];
    assign tx_ready_o = ready_q;
    assign UART_TX    = tx_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

    // Next state and next registered line/handshake values
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (tx_valid_i && ready_q) begin
                    shift_d    = frame_i;
                    byte_cnt_d = '0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = '0;
                    state_d    = START;
                    tx_d       = 1'b0;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                state_d   = DATA;
                bit_cnt_d = '0;
                tx_d      = cur_byte[0];
            end
            DATA: begin
                if (bit_cnt_q == BIT_LAST) begin
                    state_d    = STOP;
                    stop_cnt_d = '0;
                    tx_d       = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    tx_d      = cur_byte[bit_cnt_d];
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (stop_cnt_q != STOP_LAST) begin
                    stop_cnt_d = stop_cnt_q + SW'(1);
                end else if (byte_cnt_q != BYTE_LAST) begin
                    // next byte follows immediately: move it to the top
                    byte_cnt_d = byte_cnt_q + YW'(1);
                    shift_d    = shift_q << MAX_BITS;
                    state_d    = START;
                    tx_d       = 1'b0;
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forces the line idle at once
    always_ff @(posedge clk_N or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            stop_cnt_q <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: one instance at defaults (1 stop bit) and one
// with two stop bits. Expected line bits come from a frame-to-bit-list
// model; an independent line decoder rebuilds frames and compares them
// with the frames captured at accept.
module tb_uart_frame_tx;

    logic        clk;
    logic        rst;
    logic [47:0] frame_a, frame_b;
    logic        valid_a, valid_b;
    logic        ready_a, ready_b;
    logic        tx_a, tx_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;

    int tests_run = 0;
    int tests_failed = 0;

    logic [47:0] exp_q[$];   // frames accepted by DUT A, awaiting decode
    logic        exp_bits[$];
    logic        line_q[$];

    uart_frame_tx #(.MAX_BITS(8), .PARAMETERS(6), .STOP_BITS(1)) u_dut_a (
        .clk_N(clk), .rst_i(rst), .frame_i(frame_a), .tx_valid_i(valid_a),
        .tx_ready_o(ready_a), .UART_TX(tx_a), .busy_o(busy_a), .done_o(done_a)
    );

    uart_frame_tx #(.MAX_BITS(8), .PARAMETERS(6), .STOP_BITS(2)) u_dut_b (
        .clk_N(clk), .rst_i(rst), .frame_i(frame_b), .tx_valid_i(valid_b),
        .tx_ready_o(ready_b), .UART_TX(tx_b), .busy_o(busy_b), .done_o(done_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [47:0] rand48();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[47:0];
    endfunction

    // Model: a frame becomes, per byte from the top, 0, data LSB first, stop 1s
    task automatic build_bits(input logic [47:0] f, input int stops);
        logic [7:0] b;
        exp_bits.delete();
        for (int i = 0; i < 6; i++) begin
            b = f[47 - 8*i -: 8];
            exp_bits.push_back(1'b0);
            for (int j = 0; j < 8; j++) exp_bits.push_back(b[j]);
            for (int s = 0; s < stops; s++) exp_bits.push_back(1'b1);
        end
    endtask

    // Line decoder for DUT A
    initial begin : decoder
        int         pos;
        int         nbytes;
        logic [7:0] cur;
        logic [47:0] got, want;
        pos = -1; nbytes = 0; cur = '0; got = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pos = -1; nbytes = 0; got = '0;
            end else if (pos < 0) begin
                if (tx_a == 1'b0) pos = 1;
            end else if (pos <= 8) begin
                cur[pos-1] = tx_a;
                pos++;
            end else begin
                tests_run++;
                if (tx_a !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL dec_stop: got %b need 1", tx_a);
                end
                got = {got[39:0], cur};
                pos = -1;
                nbytes++;
                if (nbytes == 6) begin
                    nbytes = 0;
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL dec_frame: decoded %h with no frame accepted", got);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            tests_failed++;
                            $display("FAIL dec_frame: got %h need %h", got, want);
                        end
                    end
                end
            end
        end
    end

    // Wait (bounded) for DUT A idle; returns 0 on timeout after logging
    task automatic wait_ready_a(output bit ok);
        int waited = 0;
        while (ready_a !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        ok = (ready_a === 1'b1);
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL ready_a_timeout: tx_ready_o=%b after %0d cycles", ready_a, waited);
        end
    endtask

    // Send one frame on DUT A and check every line bit plus completion.
    // During the frame frame_i is set to next_f (or random noise if scramble),
    // and tx_valid_i stays high when keep_valid is set.
    task automatic run_a(input logic [47:0] f, input logic [47:0] next_f,
                         input bit keep_valid, input bit scramble);
        bit ok;
        wait_ready_a(ok);
        if (!ok) return;
        frame_a = f;
        valid_a = 1'b1;
        exp_q.push_back(f);
        build_bits(f, 1);
        line_q.delete();
        @(posedge clk);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            line_q.push_back(tx_a);
            tests_run++;
            if (tx_a !== exp_bits[k] || done_a !== 1'b0 || busy_a !== 1'b1 || ready_a !== 1'b0) begin
                tests_failed++;
                $display("FAIL frame_bit %0d: tx=%b done=%b busy=%b ready=%b need tx=%b done=0 busy=1 ready=0",
                         k, tx_a, done_a, busy_a, ready_a, exp_bits[k]);
            end
            frame_a = (scramble && k < 59) ? rand48() : next_f;
            valid_a = keep_valid;
        end
        @(negedge clk);
        tests_run++;
        if (done_a !== 1'b1 || tx_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_end: done=%b tx=%b ready=%b busy=%b need 1 1 1 0",
                     done_a, tx_a, ready_a, busy_a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        frame_a = '0; frame_b = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (tx_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_a: tx=%b ready=%b busy=%b done=%b need 1 1 0 0", tx_a, ready_a, busy_a, done_a);
        end
        tests_run++;
        if (tx_b !== 1'b1 || ready_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_b: tx=%b ready=%b busy=%b done=%b need 1 1 0 0", tx_b, ready_b, busy_b, done_b);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (tx_a !== 1'b1 || ready_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_after_reset: tx=%b ready=%b need 1 1", tx_a, ready_a);
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] first_exp;
        logic [9:0] last_exp;
        logic [9:0] first_got;
        logic [9:0] last_got;
        first_exp = 10'b10_0000_0010;  // 0,1,0,0,0,0,0,0,0,1 from index 0
        last_exp  = 10'b10_0001_1110;  // 0,1,1,1,1,0,0,0,0,1 from index 0
        run_a(48'h01AA5500FF0F, 48'h0, 1'b0, 1'b0);
        tests_run++;
        if (line_q.size() != 60) begin
            tests_failed++;
            $display("FAIL single_len: got %0d bits need 60", line_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                first_got[i] = line_q[i];
                last_got[i]  = line_q[50+i];
            end
            tests_run++;
            if (first_got !== first_exp) begin
                tests_failed++;
                $display("FAIL single_first_byte: got %b need %b (bit0 rightmost)", first_got, first_exp);
            end
            tests_run++;
            if (last_got !== last_exp) begin
                tests_failed++;
                $display("FAIL single_last_byte: got %b need %b (bit0 rightmost)", last_got, last_exp);
            end
        end
        @(negedge clk);
        tests_run++;
        if (done_a !== 1'b0 || tx_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_one_cycle: done=%b tx=%b need 0 1", done_a, tx_a);
        end
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 4; n++) run_a(rand48(), 48'h0, 1'b0, 1'b0);
    endtask

    // valid held, frame_i scrambled during the frame, then a back-to-back pair
    task automatic test_back_to_back();
        logic [47:0] f2;
        f2 = rand48();
        run_a(rand48(), f2, 1'b1, 1'b1);
        run_a(f2, 48'h02112233440F, 1'b1, 1'b0);
        run_a(48'h02112233440F, 48'h01000000000F, 1'b1, 1'b0);
        run_a(48'h01000000000F, 48'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        tests_run++;
        if (tx_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_b2b: tx=%b ready=%b busy=%b need 1 1 0", tx_a, ready_a, busy_a);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        logic [47:0] f;
        wait_ready_a(ok);
        if (!ok) return;
        f = rand48();
        frame_a = f;
        valid_a = 1'b1;
        exp_q.push_back(f);
        build_bits(f, 1);
        @(posedge clk);
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            valid_a = 1'b0;
            tests_run++;
            if (tx_a !== exp_bits[k]) begin
                tests_failed++;
                $display("FAIL pre_reset_bit %0d: got %b need %b", k, tx_a, exp_bits[k]);
            end
        end
        void'(exp_q.pop_back());  // this frame is aborted, never decoded
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (tx_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: tx=%b ready=%b busy=%b done=%b need 1 1 0 0", tx_a, ready_a, busy_a, done_a);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (done_a !== 1'b0 || tx_a !== 1'b1) begin
                tests_failed++;
                $display("FAIL in_reset %0d: done=%b tx=%b need 0 1", k, done_a, tx_a);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        run_a(rand48(), 48'h0, 1'b0, 1'b0);
    endtask

    task automatic test_two_stop_bits(input logic [47:0] f);
        int waited = 0;
        while (ready_b !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if (ready_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_b_timeout: tx_ready_o=%b", ready_b);
            return;
        end
        frame_b = f;
        valid_b = 1'b1;
        build_bits(f, 2);
        @(posedge clk);
        for (int k = 0; k < 66; k++) begin
            @(negedge clk);
            valid_b = 1'b0;
            tests_run++;
            if (tx_b !== exp_bits[k] || done_b !== 1'b0 || busy_b !== 1'b1) begin
                tests_failed++;
                $display("FAIL stop2_bit %0d: tx=%b done=%b busy=%b need tx=%b done=0 busy=1",
                         k, tx_b, done_b, busy_b, exp_bits[k]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (done_b !== 1'b1 || tx_b !== 1'b1 || ready_b !== 1'b1 || busy_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop2_end: done=%b tx=%b ready=%b busy=%b need 1 1 1 0", done_b, tx_b, ready_b, busy_b);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_random_frames();
        test_back_to_back();
        test_reset_mid_frame();
        test_two_stop_bits(48'hFFFFFFFFFFFF);
        test_two_stop_bits(rand48());
        repeat (5) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL undecoded_frames: %0d left need 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 The block SHALL have parameter MAX_BITS, default 8, meaning data bits per byte.
REQ-002 The block SHALL have parameter PARAMETERS, default 6, meaning bytes per frame.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, legal values 1 or 2, meaning stop bits per byte.
REQ-004 clk_N  input  1  bit-rate clock; one serial bit per rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 frame_i  input  MAX_BITS*PARAMETERS  frame to send; byte 0 is frame_i[top byte].
REQ-007 tx_valid_i  input  1  frame_i holds a frame to send.
REQ-008 tx_ready_o  output  1  block is idle and accepts a frame this cycle.
REQ-009 UART_TX  output  1  serial line; idles high.
REQ-010 busy_o  output  1  a frame is being transmitted.
REQ-011 done_o  output  1  one-cycle pulse when a frame completes.

Function
REQ-012 All outputs SHALL be registered on clk_N.
REQ-013 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-014 Accept: on an edge where tx_valid_i=1 and tx_ready_o=1, the block SHALL:
- latch frame_i into an internal shift register;
- clear byte_cnt;
- enter START.
REQ-015 After acceptance, frame_i and tx_valid_i SHALL be ignored until the block returns to IDLE.
REQ-016 Byte order SHALL be most-significant byte first (frame_i[47:40] first at default parameters).
REQ-017 Bit order within a byte SHALL be LSB first.
REQ-018 START SHALL drive UART_TX=0 for exactly one clk_N cycle, then go to DATA with bit_cnt=0.
REQ-019 DATA SHALL drive bit bit_cnt of the current byte for one cycle per bit; after bit MAX_BITS-1 it SHALL go to STOP.
REQ-020 STOP SHALL drive UART_TX=1 for STOP_BITS cycles, then:
- if byte_cnt<PARAMETERS-1: increment byte_cnt and go to START, with no idle gap;
- else: go to IDLE.
REQ-021 Timing at default parameters: with acceptance at edge E0, UART_TX SHALL carry:
- start bit during E0..E1;
- data bit i during E(1+i)..E(2+i);
- stop bit during E9..E10;
- next start bit from E10.
REQ-022 Total frame length SHALL be PARAMETERS*(1+MAX_BITS+STOP_BITS) cycles (60 at defaults).
REQ-023 At the final STOP exit edge, the block SHALL:
- set done_o=1 for exactly one cycle;
- set tx_ready_o=1;
- clear busy_o.
REQ-024 tx_ready_o SHALL be 1 only in IDLE and busy_o SHALL equal NOT tx_ready_o.
REQ-025 Back-to-back: at least one idle-high cycle SHALL separate frames; the earliest next accept is the edge after done_o rises.
REQ-026 In IDLE, UART_TX SHALL be 1.
REQ-027 Counter widths SHALL be clog2-sized with no wrap-around inside a frame.

Reset
REQ-028 While rst_i=1, the block SHALL hold: UART_TX=1, tx_ready_o=1, busy_o=0, done_o=0, state IDLE, counters 0 and shift register 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, with UART_TX=1 and no done_o pulse.
REQ-030 After reset release, the next frame SHALL start cleanly from byte 0.

Verification
REQ-031 Single frame 0x01_AA_55_00_FF_0F -> 60 cycles on UART_TX:
- first 10 bits 0,1,0,0,0,0,0,0,0,1;
- last byte bits 0,1,1,1,1,0,0,0,0,1;
- done_o pulses once at cycle 60.
REQ-032 tx_valid_i held high with frame_i changing during transmission -> the transmitted bits match the frame latched at accept; no second accept until after done_o.
REQ-033 Back-to-back frames 0x02_11_22_33_44_0F then 0x01_00_00_00_00_0F -> exactly one idle-high cycle between them; both decode correctly.
REQ-034 rst_i pulsed during byte 3 of a frame -> UART_TX=1 asynchronously, no done_o, tx_ready_o=1; a subsequent frame decodes correctly.
REQ-035 STOP_BITS=2 with frame 0xFF repeated -> 66 cycles (6*11); two high bits after each byte.
REQ-036 A scoreboard SHALL decode UART_TX (start=0, 8 data bits LSB first, stop=1) and compare each frame against frame_i captured at accept.
